// File: rtl/occ_reader.sv
// Occurrence-table read client for BWT backward search: reads the OCC lines holding two
// positions and returns Occ(base, pos) = line checkpoint + in-line prefix count for each.
module occ_reader #(
    parameter int DEPTH      = 18,
    parameter int WIDTHS     = 1920,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_W      = 32,
    parameter int LOG_BPL    = 9,
    parameter int POS_W      = ADDR_WIDTH + LOG_BPL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_base,
    input  logic [POS_W-1:0]      req_pos0,
    input  logic [POS_W-1:0]      req_pos1,
    output logic                  rEn,
    output logic [ADDR_WIDTH-1:0] rAddr0,
    output logic [ADDR_WIDTH-1:0] rAddr1,
    input  logic [WIDTHS-1:0]     rData0,
    input  logic [WIDTHS-1:0]     rData1,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [CNT_W-1:0]      resp_occ0,
    output logic [CNT_W-1:0]      resp_occ1,
    output logic                  resp_err,
    output logic [2:0]            o_dbg_state
);

    localparam int BPL      = 1 << LOG_BPL;
    localparam int BASE_LSB = 4 * CNT_W;

    // S_WAIT covers the SRAM's second register stage: data read at RD is usable in CNT.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_CNT  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [LOG_BPL-1:0]    r_off0;
    logic [LOG_BPL-1:0]    r_off1;
    logic [1:0]            r_base;
    logic                  r_oor0;
    logic                  r_oor1;
    logic [CNT_W-1:0]      r_occ0;
    logic [CNT_W-1:0]      r_occ1;
    logic                  r_err;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_line0;
    logic [ADDR_WIDTH-1:0] w_line1;
    logic                  w_oor0;
    logic                  w_oor1;

    function automatic logic [CNT_W-1:0] prefix_occ(input logic [WIDTHS-1:0] line,
                                                    input logic [1:0] base,
                                                    input logic [LOG_BPL-1:0] off);
        logic [CNT_W-1:0] ckpt;
        logic [LOG_BPL:0] cnt;
        ckpt = line[int'(base)*CNT_W +: CNT_W];
        cnt  = '0;
        for (int i = 0; i < BPL; i++) begin
            if (i < int'(off) && line[BASE_LSB + 2*i +: 2] == base) begin
                cnt = cnt + (LOG_BPL+1)'(1);
            end
        end
        return ckpt + CNT_W'(cnt);
    endfunction

    assign w_line0  = req_pos0[POS_W-1:LOG_BPL];
    assign w_line1  = req_pos1[POS_W-1:LOG_BPL];
    assign w_oor0   = (int'(w_line0) >= DEPTH);
    assign w_oor1   = (int'(w_line1) >= DEPTH);
    assign w_accept = req_valid & req_ready;

    // Handshakes: a request transfers on an edge where req_valid && req_ready; a response
    // holds resp_valid and stable data until an edge where resp_ready is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        rEn        = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = ~rst;
                if (req_valid) w_next = S_RD;
            end
            S_RD: begin
                rEn    = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: w_next = S_CNT;
            S_CNT:  w_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_off0  <= '0;
            r_off1  <= '0;
            r_base  <= '0;
            r_oor0  <= 1'b0;
            r_oor1  <= 1'b0;
            r_occ0  <= '0;
            r_occ1  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr0 <= w_line0;
                r_addr1 <= w_line1;
                r_off0  <= req_pos0[LOG_BPL-1:0];
                r_off1  <= req_pos1[LOG_BPL-1:0];
                r_base  <= req_base;
                r_oor0  <= w_oor0;
                r_oor1  <= w_oor1;
            end
            // An out-of-range port still reads (truncated address) but its data is dropped.
            if (r_state == S_CNT) begin
                r_occ0 <= r_oor0 ? '0 : prefix_occ(rData0, r_base, r_off0);
                r_occ1 <= r_oor1 ? '0 : prefix_occ(rData1, r_base, r_off1);
                r_err  <= r_oor0 | r_oor1;
            end
        end
    end

    assign rAddr0      = r_addr0;
    assign rAddr1      = r_addr1;
    assign resp_occ0   = r_occ0;
    assign resp_occ1   = r_occ1;
    assign resp_err    = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_occ_reader.sv
// Bench for occ_reader: SRAM model with a two-edge read pipe, directed and random requests,
// and a queue-based scoreboard fed from an array-level Occ reference model.
module tb_occ_reader;
    localparam int DEPTH      = 18;
    localparam int WIDTHS     = 1920;
    localparam int ADDR_WIDTH = 5;
    localparam int CNT_W      = 32;
    localparam int LOG_BPL    = 9;
    localparam int POS_W      = ADDR_WIDTH + LOG_BPL;
    localparam int BPL        = 512;
    localparam int NLINES     = 32;
    localparam int BASE_END   = 4*CNT_W + 2*BPL;
    localparam int EXP_W      = 2*CNT_W + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_base;
    logic [POS_W-1:0]      req_pos0;
    logic [POS_W-1:0]      req_pos1;
    logic                  rEn;
    logic [ADDR_WIDTH-1:0] rAddr0;
    logic [ADDR_WIDTH-1:0] rAddr1;
    logic [WIDTHS-1:0]     rData0;
    logic [WIDTHS-1:0]     rData1;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [CNT_W-1:0]      resp_occ0;
    logic [CNT_W-1:0]      resp_occ1;
    logic                  resp_err;
    logic [2:0]            o_dbg_state;

    logic [CNT_W-1:0]  ckpt_m [NLINES][4];
    logic [1:0]        base_m [NLINES][BPL];
    logic [WIDTHS-1:0] mem [NLINES];

    logic [EXP_W-1:0] exp_q[$];
    int               acc_q[$];
    logic [EXP_W-1:0] mon_e;
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               bp_mode = 0;
    logic             prev_valid = 1'b0;
    logic             en_q = 1'b0;
    logic [ADDR_WIDTH-1:0] a0_q = '0;
    logic [ADDR_WIDTH-1:0] a1_q = '0;

    occ_reader dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
        .req_pos0(req_pos0), .req_pos1(req_pos1),
        .rEn(rEn), .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(rData0), .rData1(rData1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_occ0(resp_occ0), .resp_occ1(resp_occ1), .resp_err(resp_err),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: address sampled at the edge ending the rEn cycle, data presented one edge later.
    // Outside a read the outputs are scrambled so early or late sampling is visible.
    always @(posedge clk) begin
        en_q <= rEn;
        a0_q <= rAddr0;
        a1_q <= rAddr1;
        if (en_q) begin
            rData0 <= mem[a0_q];
            rData1 <= mem[a1_q];
        end else begin
            rData0 <= ~rData0;
            rData1 <= ~rData1;
        end
    end

    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 2) != 0);
            default: resp_ready = 1'b0;
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not as expected", name);
    endtask

    // Occ straight from the definition: checkpoint plus a count over the first off bases.
    function automatic logic [CNT_W-1:0] model_occ(input int base, input int pos);
        int line;
        int off;
        logic [CNT_W-1:0] n;
        line = pos / BPL;
        off  = pos % BPL;
        n    = '0;
        if (line >= DEPTH) return '0;
        for (int i = 0; i < off; i++) begin
            if (int'(base_m[line][i]) == base) n++;
        end
        return ckpt_m[line][base] + n;
    endfunction

    task automatic build_mem();
        for (int l = 0; l < NLINES; l++) begin
            mem[l] = '0;
            for (int k = 0; k < 4; k++) mem[l][k*CNT_W +: CNT_W] = ckpt_m[l][k];
            for (int i = 0; i < BPL; i++) mem[l][4*CNT_W + 2*i +: 2] = base_m[l][i];
            for (int j = BASE_END; j < WIDTHS; j++) mem[l][j] = 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input int base, input int p0, input int p1,
                        input logic [CNT_W-1:0] e0, input logic [CNT_W-1:0] e1,
                        input logic e_err);
        int n;
        req_base  = 2'(base);
        req_pos0  = POS_W'(p0);
        req_pos1  = POS_W'(p1);
        req_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (n == 200) fail_now("req_ready_timeout");
        @(posedge clk);
        exp_q.push_back({e_err, e0, e1});
        #1;
        acc_q.push_back(cyc);
        req_valid = 1'b0;
    endtask

    task automatic send_model(input int base, input int p0, input int p1);
        logic e_err;
        e_err = ((p0 / BPL) >= DEPTH) || ((p1 / BPL) >= DEPTH);
        send(base, p0, p1, model_occ(base, p0), model_occ(base, p1), e_err);
    endtask

    task automatic wait_drain(input string name);
        int n;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (resp_valid && !prev_valid) begin
            if (acc_q.size() == 0) fail_now("unexpected_resp");
            else check("latency", 64'(cyc - acc_q[0]), 64'd3);
        end
        if (resp_valid && resp_ready && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            void'(acc_q.pop_front());
            check("resp_occ0", 64'(resp_occ0), 64'(mon_e[2*CNT_W-1:CNT_W]));
            check("resp_occ1", 64'(resp_occ1), 64'(mon_e[CNT_W-1:0]));
            check("resp_err", 64'(resp_err), 64'(mon_e[2*CNT_W]));
        end
        prev_valid <= resp_valid;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int p0;
        int p1;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_base  = '0;
        req_pos0  = '0;
        req_pos1  = '0;

        for (int l = 0; l < NLINES; l++) begin
            for (int k = 0; k < 4; k++) ckpt_m[l][k] = $urandom();
            for (int i = 0; i < BPL; i++) base_m[l][i] = 2'($urandom_range(0, 3));
        end
        ckpt_m[3][0] = 100;
        ckpt_m[3][1] = 200;
        ckpt_m[3][2] = 300;
        ckpt_m[3][3] = 400;
        for (int i = 0; i < BPL; i++) base_m[3][i] = (i < 10) ? 2'd1 : 2'd0;
        ckpt_m[7][2] = 32'hFFFF_FFFE;
        for (int i = 0; i < 5; i++) base_m[7][i] = 2'd2;
        build_mem();

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("req_ready_in_reset", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rEn", 64'(rEn), 64'd0);
        check("rst_rAddr0", 64'(rAddr0), 64'd0);
        check("rst_rAddr1", 64'(rAddr1), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_occ0", 64'(resp_occ0), 64'd0);
        check("rst_occ1", 64'(resp_occ1), 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        @(posedge clk);
        #1;

        // directed cases
        send(1, 1546, 1536, 210, 200, 1'b0);
        send(0, 1547, 2047, 101, 601, 1'b0);
        send(1, 9216, 1546, 0, 210, 1'b1);
        send(2, 7*512 + 5, 7*512 + 5, 3, 3, 1'b0);
        wait_drain("drain_directed");

        // backpressure
        @(posedge clk);
        #1 bp_mode = 2;
        @(posedge clk);
        #3;
        send(1, 1540, 9300, 204, 0, 1'b1);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        if (n == 20) fail_now("bp_resp_timeout");
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 64'(resp_valid), 64'd1);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_occ0", 64'(resp_occ0), 64'd204);
            check("stall_occ1", 64'(resp_occ1), 64'd0);
            check("stall_err", 64'(resp_err), 64'd1);
            @(negedge clk);
        end
        bp_mode = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!resp_valid) break;
        end
        check("release_req_ready", 64'(req_ready), 64'd1);
        wait_drain("drain_bp");

        // reset during RD
        @(posedge clk);
        #1;
        req_base  = 2'd1;
        req_pos0  = POS_W'(1546);
        req_pos1  = POS_W'(1546);
        req_valid = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("rd_rEn", 64'(rEn), 64'd1);
        check("rd_rAddr0", 64'(rAddr0), 64'd3);
        check("rd_rAddr1", 64'(rAddr1), 64'd3);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_rEn", 64'(rEn), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_occ0", 64'(resp_occ0), 64'd0);
        for (int k = 0; k < 8; k++) begin
            check("midrst_no_resp", 64'(resp_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send(1, 1546, 1546, 210, 210, 1'b0);
        wait_drain("drain_after_rst");

        // random traffic with random backpressure
        @(posedge clk);
        #1 bp_mode = 1;
        for (int t = 0; t < 40; t++) begin
            p0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383))
                                             : int'($urandom_range(0, DEPTH*BPL - 1));
            p1 = ($urandom_range(0, 4) == 0) ? p0 : int'($urandom_range(0, DEPTH*BPL + 700));
            send_model(int'($urandom_range(0, 3)), p0, p1);
        end
        @(posedge clk);
        #1 bp_mode = 0;
        wait_drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
